// File: rtl/stbus_pkg.sv
// Shared constants for the ST-bus frame transmitter: frame geometry, channel indexing
// and the default idle byte, plus the MSB-first bit-select helper.
package stbus_pkg;
  localparam int STBUS_CHANNELS = 32;
  localparam int STBUS_CH_W     = 5;
  localparam int STBUS_FRAME_C4 = 512;
  localparam int STBUS_FC_W     = 9;
  localparam logic [7:0] STBUS_IDLE_BYTE = 8'hFF;

  typedef logic [7:0]            ch_byte_t;
  typedef logic [STBUS_CH_W-1:0] ch_idx_t;

  // Serial position within a channel (fc[3:1]) to byte bit index, MSB first.
  function automatic logic [2:0] bit_sel(input logic [2:0] pos);
    return 3'd7 - pos;
  endfunction
endpackage

// File: rtl/stbus_tx_chbuf.sv
// Double-banked 32x8 channel buffer: writes go to the shadow bank, the read port sees the
// active bank, and after each swap the new shadow is refilled from the new active bank.
module stbus_tx_chbuf
  import stbus_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = STBUS_IDLE_BYTE
) (
  input  logic       clk50,
  input  logic       reset_tx,
  input  logic       wr_en,
  input  logic [4:0] wr_ch,
  input  logic [7:0] wr_data,
  input  logic       swap,
  input  logic [4:0] rd_ch,
  output logic [7:0] rd_data
);

  logic       active_reg;      // 0: bank a active, bank b shadow
  logic       copy_busy_reg;
  ch_idx_t    copy_idx_reg;
  ch_byte_t   a_q [STBUS_CHANNELS];
  ch_byte_t   b_q [STBUS_CHANNELS];
  logic       read_b;

  always_ff @(posedge clk50) begin
    if (reset_tx) begin
      active_reg    <= 1'b0;
      copy_busy_reg <= 1'b0;
      copy_idx_reg  <= '0;
    end else if (swap) begin
      active_reg    <= ~active_reg;
      copy_busy_reg <= 1'b1;
      copy_idx_reg  <= '0;
    end else if (copy_busy_reg) begin
      copy_idx_reg <= copy_idx_reg + 1'b1;
      if (&copy_idx_reg) copy_busy_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < STBUS_CHANNELS; gi++) begin : g_ch
    ch_byte_t bank_a_reg;
    ch_byte_t bank_b_reg;
    logic     dirty_reg;     // written since the last swap: the copy must not clobber it
    logic     wr_hit;
    logic     cp_hit;

    assign wr_hit = wr_en && (wr_ch == STBUS_CH_W'(gi));
    assign cp_hit = copy_busy_reg && (copy_idx_reg == STBUS_CH_W'(gi)) && !dirty_reg;

    always_ff @(posedge clk50) begin
      if (reset_tx) begin
        bank_a_reg <= IDLE_BYTE;
        bank_b_reg <= IDLE_BYTE;
        dirty_reg  <= 1'b0;
      end else begin
        if (active_reg) begin
          if (wr_hit)      bank_a_reg <= wr_data;
          else if (cp_hit) bank_a_reg <= bank_b_reg;
        end else begin
          if (wr_hit)      bank_b_reg <= wr_data;
          else if (cp_hit) bank_b_reg <= bank_a_reg;
        end
        dirty_reg <= swap ? 1'b0 : (dirty_reg | wr_hit);
      end
    end

    assign a_q[gi] = bank_a_reg;
    assign b_q[gi] = bank_b_reg;
  end

  // On a swap edge the serializer needs the post-swap active bank (the pre-swap shadow),
  // including a write landing in that same cycle.
  assign read_b  = active_reg ^ swap;
  assign rd_data = (swap && wr_en && (wr_ch == rd_ch)) ? wr_data
                 : (read_b ? b_q[rd_ch] : a_q[rd_ch]);

endmodule

// File: rtl/stbus_frame_tx.sv
// ST-bus frame transmitter: c4 divider, 512-count frame counter, f0/data serializer and
// bank-swap commit logic. Define STBUS_TX_TEST_PATTERN_EN to enable the test_mode pattern.
module stbus_frame_tx
  import stbus_pkg::*;
#(
  parameter int         C4_HALF   = 6,
  parameter logic [7:0] IDLE_BYTE = STBUS_IDLE_BYTE
) (
  input  logic       clk50,
  input  logic       reset_tx,
  input  logic       wr_en,
  input  logic [4:0] wr_ch,
  input  logic [7:0] wr_data,
  input  logic       wr_commit,
  input  logic       test_mode,
  output logic       c4,
  output logic       f0_n,
  output logic       data_out,
  output logic       frame_start,
  output logic       commit_pending
);

  localparam int DIV_W = $clog2(C4_HALF);

  logic [DIV_W-1:0]      div_reg;
  logic                  c4_reg;
  logic                  started_reg;
  logic [STBUS_FC_W-1:0] fc_reg;
  logic [STBUS_FC_W-1:0] fc_next;
  logic                  f0_n_reg;
  logic                  data_reg;
  logic                  frame_start_reg;
  logic                  pending_reg;
  logic                  rise;
  logic                  boundary;
  logic                  swap;
  logic [7:0]            rd_data;
  logic [7:0]            tx_byte;

  assign rise     = (div_reg == DIV_W'(C4_HALF - 1)) && !c4_reg;
  // fc stays at 0 through the first c4 period after reset so that period is a frame start
  assign fc_next  = started_reg ? fc_reg + 1'b1 : '0;
  assign boundary = rise && (fc_next == '0);
  assign swap     = boundary && pending_reg;

  always_ff @(posedge clk50) begin
    if (reset_tx) begin
      div_reg <= '0;
      c4_reg  <= 1'b0;
    end else if (div_reg == DIV_W'(C4_HALF - 1)) begin
      div_reg <= '0;
      c4_reg  <= ~c4_reg;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (reset_tx) begin
      fc_reg          <= '0;
      started_reg     <= 1'b0;
      f0_n_reg        <= 1'b1;
      data_reg        <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= boundary;
      if (rise) begin
        fc_reg      <= fc_next;
        started_reg <= 1'b1;
        f0_n_reg    <= (fc_next != '0);
        if (!fc_next[0]) data_reg <= tx_byte[bit_sel(fc_next[3:1])];
      end
    end
  end

  // A commit arriving in the swap cycle re-arms for the following boundary.
  always_ff @(posedge clk50) begin
    if (reset_tx) pending_reg <= 1'b0;
    else          pending_reg <= swap ? wr_commit : (pending_reg | wr_commit);
  end

  stbus_tx_chbuf #(
    .IDLE_BYTE(IDLE_BYTE)
  ) u_chbuf (
    .clk50   (clk50),
    .reset_tx(reset_tx),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .swap    (swap),
    .rd_ch   (fc_next[8:4]),
    .rd_data (rd_data)
  );

`ifdef STBUS_TX_TEST_PATTERN_EN
  assign tx_byte = test_mode ? {3'b000, fc_next[8:4]} : rd_data;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign tx_byte          = rd_data;
`endif

  assign c4             = c4_reg;
  assign f0_n           = f0_n_reg;
  assign data_out       = data_reg;
  assign frame_start    = frame_start_reg;
  assign commit_pending = pending_reg;

endmodule

// File: tb/tb_stbus_frame_tx.sv
// Scoreboard bench for stbus_frame_tx: a bank-level model predicts every c4 rising edge,
// a negedge monitor pops and compares them and checks hold/reset behaviour every cycle.
module tb_stbus_frame_tx;
  localparam int H     = 6;
  localparam int P     = 2 * H;
  localparam int FRAME = 512;

  logic       clk50 = 1'b0;
  logic       reset_tx, wr_en, wr_commit, test_mode;
  logic [4:0] wr_ch;
  logic [7:0] wr_data;
  logic       c4, f0_n, data_out, frame_start, commit_pending;

  stbus_frame_tx #(.C4_HALF(H), .IDLE_BYTE(8'hFF)) dut (
    .clk50         (clk50),
    .reset_tx      (reset_tx),
    .wr_en         (wr_en),
    .wr_ch         (wr_ch),
    .wr_data       (wr_data),
    .wr_commit     (wr_commit),
    .test_mode     (test_mode),
    .c4            (c4),
    .f0_n          (f0_n),
    .data_out      (data_out),
    .frame_start   (frame_start),
    .commit_pending(commit_pending)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    int   cyc;
    int   fc;
    logic f0;
    logic fs;
    logic d;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_active [32];
  logic [7:0] m_shadow [32];
  int         n        = 0;
  logic       armed    = 1'b0;
  logic       rst_seen = 1'b0;
  logic       exp_bit  = 1'b1;

  function automatic int rise_at(input int f, input int fc);
    return H + (f * FRAME + fc) * P;
  endfunction

  // Reference model: clk50 edges counted since reset release, c4 rises every P cycles.
  always @(posedge clk50) begin
    exp_t       e;
    logic [7:0] b;
    int         fc;
    logic       swapped;
    if (reset_tx) begin
      n        = 0;
      armed    = 1'b0;
      rst_seen = 1'b1;
      exp_bit  = 1'b1;
      q.delete();
      for (int i = 0; i < 32; i++) begin
        m_active[i] = 8'hFF;
        m_shadow[i] = 8'hFF;
      end
    end else begin
      rst_seen = 1'b0;
      n++;
      swapped = 1'b0;
      if (wr_en) m_shadow[wr_ch] = wr_data;
      if (n % P == H) begin
        fc = ((n - H) / P) % FRAME;
        if (fc == 0 && armed) begin
          m_active = m_shadow;
          armed    = 1'b0;
          swapped  = 1'b1;
        end
        if (fc % 2 == 0) begin
          b = m_active[fc / 16];
`ifdef STBUS_TX_TEST_PATTERN_EN
          if (test_mode) b = 8'(fc / 16);
`endif
          exp_bit = b[7 - (fc % 16) / 2];
        end
        e.cyc = n;
        e.fc  = fc;
        e.f0  = (fc != 0);
        e.fs  = (fc == 0);
        e.d   = exp_bit;
        q.push_back(e);
      end
      armed = swapped ? wr_commit : (armed | wr_commit);
    end
  end

  // Monitor
  logic prev_c4 = 1'b0;
  logic last_f0 = 1'b1;
  logic last_d  = 1'b1;
  always @(negedge clk50) begin
    exp_t e;
    if (rst_seen) begin
      total++;
      if ({c4, f0_n, data_out, frame_start, commit_pending} !== 5'b01100) begin
        bad++;
        $display("FAIL reset_outs: got c4/f0_n/data/fs/pend=%b want 01100",
                 {c4, f0_n, data_out, frame_start, commit_pending});
      end
      last_f0 = 1'b1;
      last_d  = 1'b1;
      prev_c4 = 1'b0;
    end else begin
      if (c4 === 1'b1 && prev_c4 === 1'b0) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rise: got c4 rise at cycle %0d want none", n);
        end else begin
          e = q.pop_front();
          if (n != e.cyc || f0_n !== e.f0 || frame_start !== e.fs || data_out !== e.d ||
              commit_pending !== armed) begin
            bad++;
            $display("FAIL rise fc=%0d: got cyc=%0d f0_n=%b fs=%b d=%b pend=%b want cyc=%0d f0_n=%b fs=%b d=%b pend=%b",
                     e.fc, n, f0_n, frame_start, data_out, commit_pending,
                     e.cyc, e.f0, e.fs, e.d, armed);
          end
          last_f0 = e.f0;
          last_d  = e.d;
          if (e.fc == 0) $display("frame start at cycle %0d, first bit %b, pending %b", n, data_out, commit_pending);
        end
      end else begin
        total++;
        if ({f0_n, data_out, frame_start, commit_pending} !== {last_f0, last_d, 1'b0, armed}) begin
          bad++;
          $display("FAIL hold cyc=%0d: got f0_n/data/fs/pend=%b want %b", n,
                   {f0_n, data_out, frame_start, commit_pending}, {last_f0, last_d, 1'b0, armed});
        end
      end
      prev_c4 = c4;
    end
  end

  task automatic go_to(input int target);
    int g = 0;
    while (n < target && g < 200000) begin
      @(negedge clk50);
      g++;
    end
    if (g >= 200000) begin
      total++;
      bad++;
      $display("FAIL go_to_timeout: got n=%0d want %0d", n, target);
    end
  endtask

  task automatic do_write(input logic [4:0] ch, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_data = d;
    @(negedge clk50);
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    wr_commit = 1'b1;
    @(negedge clk50);
    wr_commit = 1'b0;
  endtask

  task automatic check_pend(input string name, input logic want);
    total++;
    if (commit_pending !== want) begin
      bad++;
      $display("FAIL %s: got commit_pending=%b want %b", name, commit_pending, want);
    end
  endtask

  initial begin
    reset_tx  = 1'b1;
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    test_mode = 1'b0;
    wr_ch     = '0;
    wr_data   = '0;
    repeat (3) @(negedge clk50);
    reset_tx = 1'b0;

    // idle frame 0, then load ch0/ch31 and commit twice (single swap expected)
    go_to(rise_at(0, 100));
    do_write(5'd0, 8'hA5);
    do_write(5'd31, 8'h3C);
    do_commit();
    repeat (5) @(negedge clk50);
    do_commit();
    // uncommitted write stays invisible for frames 2..4
    go_to(rise_at(1, 100));
    do_write(5'd5, 8'h00);
    go_to(rise_at(4, 100));
    do_commit();
    // commit, then write ch2 in the exact swap cycle of frame 6
    go_to(rise_at(5, 100));
    do_commit();
    go_to(rise_at(6, 0) - 1);
    check_pend("pend_before_swap", 1'b1);
    wr_en   = 1'b1;
    wr_ch   = 5'd2;
    wr_data = 8'h81;
    @(negedge clk50);
    wr_en = 1'b0;
    check_pend("pend_after_swap", 1'b0);
    // reset mid-frame
    go_to(rise_at(6, 300));
    reset_tx = 1'b1;
    repeat (2) @(negedge clk50);
    reset_tx = 1'b0;

    // randomized phase: test pattern frame, random writes, commit re-armed in swap cycle
    test_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      go_to(n + $urandom_range(50, 400));
      do_write(5'($urandom_range(0, 31)), 8'($urandom));
    end
    go_to(rise_at(0, 400));
    do_commit();
    go_to(rise_at(1, 0) - 1);
    wr_commit = 1'b1;
    wr_en     = 1'b1;
    wr_ch     = 5'($urandom_range(0, 31));
    wr_data   = 8'($urandom);
    @(negedge clk50);
    wr_commit = 1'b0;
    wr_en     = 1'b0;
    check_pend("pend_rearmed", 1'b1);
    for (int i = 0; i < 6; i++) begin
      go_to(n + $urandom_range(200, 800));
      test_mode = 1'($urandom);
      do_write(5'($urandom_range(0, 31)), 8'($urandom));
    end
    go_to(rise_at(2, 40) + 2);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unconsumed rises want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2ms want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stbus_frame_tx.md
STBUS_FRAME_TX -- requirements
Module: stbus_frame_tx

Interface
REQ-001 Parameter C4_HALF, default 6, gives the clk50 cycles per c4 half-period (minimum 2).
REQ-002 Parameter IDLE_BYTE, default 8'hFF, is the byte held by every channel after reset.
REQ-003 clk50  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_tx  in  1  reset, synchronous and active-high.
REQ-005 wr_en  in  1  write strobe for the channel buffer.
REQ-006 wr_ch  in  5  channel index (0..31) written by wr_en.
REQ-007 wr_data  in  8  channel byte written by wr_en.
REQ-008 wr_commit  in  1  one-cycle pulse that arms a bank swap at the next frame boundary.
REQ-009 test_mode  in  1  selects the test pattern (see Configuration).
REQ-010 c4  out  1  generated bit-rate clock (two c4 periods per bit).
REQ-011 f0_n  out  1  frame sync, active low.
REQ-012 data_out  out  1  serial channel data, MSB first.
REQ-013 frame_start  out  1  one-clk50 pulse on the rising edge of c4 at frame count 0.
REQ-014 commit_pending  out  1  high while a commit is armed and the swap has not yet happened.

Function
REQ-015 A divider SHALL toggle c4 every C4_HALF clk50 cycles; the first c4 rising edge SHALL occur C4_HALF cycles after reset release.
REQ-016 A 9-bit frame counter fc SHALL increment on every c4 rising edge, wrap from 511 to 0, and hold 0 for the first c4 period after reset.
REQ-017 f0_n SHALL be 0 exactly while fc==0, changing on the c4 rising edge; it SHALL be 1 otherwise.
REQ-018 On each c4 rising edge with fc[0]==0, data_out SHALL be loaded with bit (7-fc[3:1]) of channel fc[8:4] from the active bank; it SHALL hold for 2 c4 periods.
REQ-019 Writes SHALL always target the shadow bank; wr_ch is 5 bits, so no out-of-range index exists.
REQ-020 On the c4 rising edge where fc wraps 511->0, if a commit is armed, active and shadow SHALL swap, the commit SHALL clear, and channel 0 bit 7 of the new active bank SHALL drive data_out on that same edge.
REQ-021 After a swap, the new shadow bank SHALL be loaded with a full copy of the new active bank within 32 clk50 cycles, so that partial updates are not lost.
REQ-022 If wr_en and the copy address the same channel in the same cycle, wr_data SHALL win.
REQ-023 If wr_en falls in the swap cycle, the write SHALL land in the pre-swap shadow bank, which becomes active, so the byte is transmitted in the new frame.
REQ-024 A wr_commit while a commit is already armed SHALL have no further effect; a single swap SHALL follow.
REQ-025 A wr_commit in the swap cycle SHALL arm the next boundary, not the current one.
REQ-026 commit_pending SHALL go high in the cycle after wr_commit and low in the cycle after the swap.

Reset
REQ-027 On reset_tx: c4=0, f0_n=1, data_out=1, frame_start=0, commit_pending=0, fc=0, and the divider cleared.
REQ-028 On reset_tx, both banks SHALL be set to IDLE_BYTE and the active bank index SHALL be 0.
REQ-029 Reset mid-frame SHALL abort immediately; after release, the first c4 period SHALL be a frame start (f0_n=0).

Configuration
REQ-030 When STBUS_TX_TEST_PATTERN_EN is defined and test_mode=1, channel n SHALL transmit byte n (8'h00..8'h1F) in place of bank data; banks SHALL remain writable.
REQ-031 When STBUS_TX_TEST_PATTERN_EN is undefined, the test_mode input SHALL exist but be ignored, and no pattern logic SHALL be synthesized.

Structure
REQ-032 Package stbus_pkg SHALL hold STBUS_CHANNELS=32, STBUS_CH_W=5, STBUS_FRAME_C4=512, STBUS_FC_W=9 and the idle-byte default.
REQ-033 Sub-module stbus_tx_chbuf SHALL implement the two 32x8 banks with write port, read port, swap and background copy.
REQ-034 The top level SHALL hold the c4 divider, frame counter, f0/data serializer and commit logic.

Verification
REQ-035 Reset release, no writes -> f0_n low for c4 periods fc=0 every 512 c4 periods; data_out constant 1.
REQ-036 Write ch0=8'hA5 and ch31=8'h3C, then commit -> next frame: fc 0..15 carries 1,0,1,0,0,1,0,1 (2 c4 each); fc 496..511 carries 0,0,1,1,1,1,0,0.
REQ-037 Write ch5=8'h00 without commit -> output unchanged for 3 frames; commit -> ch5 transmits 00 from the next frame.
REQ-038 Commit, then write ch2=8'h81 in the exact swap cycle -> 8'h81 transmitted on ch2 in the new frame; commit_pending falls the cycle after the swap.
REQ-039 Assert reset_tx at fc=300 -> outputs reach reset values the next cycle; first post-release c4 period has f0_n=0; banks read IDLE_BYTE.
REQ-040 With STBUS_TX_TEST_PATTERN_EN defined and test_mode=1 -> channel 7 transmits 00000111; with the macro undefined -> bank data is transmitted.
